// File: rtl/xalu.sv
// xalu: multi-cycle multiply/divide unit with architectural HI/LO registers.
// A Start pulse launches one op. Multiply and divide hold Busy for a fixed
// number of cycles and then commit to HI/LO. mthi and mtlo write HI/LO in a
// single cycle.
// Optional feature: define XALU_MADD_EN to enable madd (XAluOp 7).
module xalu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  XAluOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;

  logic          launch, wr_hi, wr_lo;
  logic [CW-1:0] load_val;
  logic [63:0]   prod_s, prod_u, res;
  logic          res_we;
`ifdef XALU_MADD_EN
  logic [63:0]   acc;
`endif

  // Decode the Start strobe into a multi-cycle launch or a direct HI/LO write.
  always_comb begin
    launch   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    load_val = MULT_LOAD;
    if (Start) begin
      case (XAluOp)
        OP_MULT, OP_MULTU: launch = 1'b1;
        OP_DIV, OP_DIVU: begin
          launch   = 1'b1;
          load_val = DIV_LOAD;
        end
`ifdef XALU_MADD_EN
        OP_MADD:  launch = 1'b1;
`endif
        OP_MTHI:  wr_hi = 1'b1;
        OP_MTLO:  wr_lo = 1'b1;
        default:  ;
      endcase
    end
  end

  // Products are 64-bit; operands are sign- or zero-extended before multiplying.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
`ifdef XALU_MADD_EN
  assign acc = {HI, LO} + prod_s;
`endif

  // Result of the latched op; divide by zero suppresses the write.
  always_comb begin
    res    = prod_s;
    res_we = 1'b1;
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0) res_we = 1'b0;
        else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {32'($signed(a_q) % $signed(b_q)), 32'($signed(a_q) / $signed(b_q))};
      end
      OP_DIVU: begin
        if (b_q == 32'd0) res_we = 1'b0;
        else res = {a_q % b_q, a_q / b_q};
      end
`ifdef XALU_MADD_EN
      OP_MADD:  res = acc;
`endif
      default:  res_we = 1'b0;
    endcase
  end

  // Control FSM, operand latches and the HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= XAluOp;
            cnt   <= load_val;
            state <= RUN;
            Busy  <= 1'b1;
          end else begin
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= B;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (res_we) begin
              HI <= res[63:32];
              LO <= res[31:0];
            end
            // The commit edge also acts as an idle edge so a back-to-back
            // Start keeps Busy high with no gap.
            if (launch) begin
              a_q  <= A;
              b_q  <= B;
              op_q <= XAluOp;
              cnt  <= load_val;
            end else begin
              if (wr_hi) HI <= A;
              if (wr_lo) LO <= B;
              cnt   <= '0;
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xalu.sv
// Directed bench for xalu: multiply, divide, divide by zero, async reset,
// Start while busy, back-to-back launch and the optional madd.
module tb_xalu;
  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  XAluOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .XAluOp(XAluOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Present one op for a single posedge; returns on the negedge after it.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; XAluOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; XAluOp = 3'd0;
  endtask

  // Count negedge samples with Busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Start = 1'b0; XAluOp = 3'd0; A = '0; B = '0;
    #12;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", LO); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult;
    int n;
    launch(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", n); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    total++; if (LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", LO); end
    launch(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    total++; if (HI !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
    total++; if (LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
  endtask

  task automatic test_div;
    int n;
    launch(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", n); end
    total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=0", HI); end
    launch(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++; $display("FAIL divu got=%h:%h exp=2:14", HI, LO); end
  endtask

  task automatic test_div_zero;
    int n;
    launch(3'd5, 32'h1234, 32'd0);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
    total++; if (HI !== 32'h1234) begin bad++; $display("FAIL mthi_hi got=%h exp=1234", HI); end
    launch(3'd6, 32'd0, 32'h5678);
    total++; if (LO !== 32'h5678 || HI !== 32'h1234) begin bad++; $display("FAIL mtlo got=%h:%h exp=1234:5678", HI, LO); end
    launch(3'd4, 32'd100, 32'd0);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL divz_busy got=%0d exp=10", n); end
    total++; if (HI !== 32'h1234 || LO !== 32'h5678) begin bad++; $display("FAIL divz_hilo got=%h:%h exp=1234:5678", HI, LO); end
  endtask

  task automatic test_reset_mid;
    int n;
    launch(3'd5, 32'hAAAA, 32'd0);
    launch(3'd3, 32'd50, 32'd7);
    repeat (3) @(negedge clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", Busy); end
    #1 reset = 1'b1;
    #1;
    total++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL rst_mid got=%b %h:%h exp=0 0:0", Busy, HI, LO); end
    @(negedge clk); reset = 1'b0;
    launch(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    total++; if (n != 5 || LO !== 32'd12 || HI !== 32'd0) begin
      bad++; $display("FAIL rst_mid_mult got=%0d %h:%h exp=5 0:c", n, HI, LO); end
  endtask

  task automatic test_start_in_run;
    int n;
    launch(3'd1, 32'd2, 32'd3);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 2) begin Start = 1'b1; XAluOp = 3'd1; A = 32'd5; B = 32'd5; end
      else begin Start = 1'b0; XAluOp = 3'd0; end
      @(negedge clk);
    end
    Start = 1'b0;
    total++; if (n != 5) begin bad++; $display("FAIL ignore_busy got=%0d exp=5", n); end
    total++; if (LO !== 32'd6 || HI !== 32'd0) begin bad++; $display("FAIL ignore_res got=%h:%h exp=0:6", HI, LO); end
    @(negedge clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL ignore_relaunch got=%b exp=0", Busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    launch(3'd1, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    Start = 1'b1; XAluOp = 3'd3; A = 32'd20; B = 32'd3;
    @(negedge clk);
    Start = 1'b0; XAluOp = 3'd0;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", Busy); end
    total++; if (LO !== 32'd6) begin bad++; $display("FAIL b2b_first got=%h exp=6", LO); end
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL b2b_len got=%0d exp=10", n); end
    total++; if (LO !== 32'd6 || HI !== 32'd2) begin bad++; $display("FAIL b2b_div got=%h:%h exp=2:6", HI, LO); end
  endtask

  task automatic test_madd;
    int n;
    launch(3'd5, 32'd0, 32'd0);
    launch(3'd6, 32'd0, 32'd10);
    launch(3'd7, 32'd3, 32'd4);
`ifdef XALU_MADD_EN
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL madd_busy got=%0d exp=5", n); end
    total++; if (LO !== 32'd22 || HI !== 32'd0) begin bad++; $display("FAIL madd got=%h:%h exp=0:16", HI, LO); end
    launch(3'd7, 32'hFFFF_FFFF, 32'd30);
    wait_idle(n);
    total++; if (LO !== 32'hFFFF_FFF8 || HI !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL madd_neg got=%h:%h exp=ffffffff:fffffff8", HI, LO); end
`else
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL madd_off_busy got=%b exp=0", Busy); end
    wait_idle(n);
    total++; if (n != 0) begin bad++; $display("FAIL madd_off_len got=%0d exp=0", n); end
    total++; if (LO !== 32'd10 || HI !== 32'd0) begin bad++; $display("FAIL madd_off got=%h:%h exp=0:a", HI, LO); end
`endif
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_reset_mid;
    test_start_in_run;
    test_back_to_back;
    test_madd;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
